fpu_shared_pipe: RTL and testbench

Parametrised successor to the shared-interconnect FPU wrapper: it connects one `fpu_core` to the shared APU interconnect. It adds a configurable input register, a tag/valid delay line sized to the core latency, and an output response FIFO so that upstream back-pressure is honoured. Downstream flow control is credit-based, so the non-stallable core can never overflow the FIFO. It sits between the interconnect port and `fpu_core`, in place of the fixed-latency, always-ready wrapper.

---
 rtl/fpu_defs_pkg.sv | 34 +++
 rtl/fpu_core.sv | 90 +++++++++
 rtl/fpu_shared_fifo.sv | 55 +++++
 rtl/fpu_shared_pipe.sv | 166 ++++++++++++++++
 tb/tb_fpu_shared_pipe.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_defs_pkg.sv
// Shared FPU definitions: operand/command/tag widths, response word, flag mapping.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fpu_defs;

    localparam int C_OP   = 32;
    localparam int C_CMD  = 4;
    localparam int C_RM   = 3;
    localparam int C_TAG  = 5;
    localparam int C_FLAG = 9;

    localparam logic [C_CMD-1:0] C_FPU_ADD_CMD = 4'h0;
    localparam logic [C_RM-1:0]  C_RM_NEAREST  = 3'h0;

    // One response FIFO word.
    typedef struct packed {
        logic [C_OP-1:0]   result;
        logic [C_FLAG-1:0] flags;
        logic [C_TAG-1:0]  tag;
    } fpu_resp_t;

    // Interconnect flag word, MSB first: {0, Inf, IV, IX, Zero, 0, 0, UF, OF}.
    function automatic logic [C_FLAG-1:0] fpu_map_flags(
        input logic inf_f,
        input logic iv_f,
        input logic ix_f,
        input logic zero_f,
        input logic uf_f,
        input logic of_f
    );
        return {1'b0, inf_f, iv_f, ix_f, zero_f, 1'b0, 1'b0, uf_f, of_f};
    endfunction

endpackage

// File: rtl/fpu_core.sv
// Compact single-precision adder core; non-stallable fixed pipeline.
// Latency: result LATENCY cycles after Enable_SI.
// Backpressure: none; caller must capture results when they emerge.
// Ports: operands/RM/OP/Enable in, Result plus OF/UF/Zero/IX/IV/Inf out.
module fpu_core
    import fpu_defs::*;
#(
    parameter int LATENCY = 1
) (
    input  logic              Clk_CI,
    input  logic [C_OP-1:0]   Operand_a_DI,
    input  logic [C_OP-1:0]   Operand_b_DI,
    input  logic [C_RM-1:0]   RM_SI,
    input  logic [C_CMD-1:0]  OP_SI,
    input  logic              Enable_SI,
    output logic [C_OP-1:0]   Result_DO,
    output logic              OF_SO,
    output logic              UF_SO,
    output logic              Zero_SO,
    output logic              IX_SO,
    output logic              IV_SO,
    output logic              Inf_SO
);

    localparam int W = C_OP + 6;

    logic [7:0]      w_ea, w_eb;
    logic            w_sa, w_sb;
    logic [23:0]     w_sum;
    logic [30:0]     w_em;
    logic            w_rnd;
    logic [C_OP-1:0] w_res;
    logic            w_of, w_zero, w_ix, w_inf;
    logic [W-1:0]    r_pipe [LATENCY];

    assign w_ea = Operand_a_DI[30:23];
    assign w_eb = Operand_b_DI[30:23];
    assign w_sa = Operand_a_DI[31];
    assign w_sb = Operand_b_DI[31];

    always_comb begin
        // Equal-exponent add: hidden bits make the carry-out always set, so
        // the exponent is bumped and bit 0 of the sum becomes the guard bit.
        w_sum  = {1'b1, Operand_a_DI[22:0]} + {1'b1, Operand_b_DI[22:0]};
        w_rnd  = (RM_SI == C_RM_NEAREST) & w_sum[0] & w_sum[1];
        // Rounding carry ripples from mantissa into exponent naturally.
        w_em   = {w_ea + 8'd1, w_sum[23:1]} + {30'd0, w_rnd};
        w_res  = Operand_a_DI;
        w_of   = 1'b0;
        w_zero = 1'b0;
        w_ix   = 1'b0;
        w_inf  = 1'b0;
        if (OP_SI == C_FPU_ADD_CMD) begin
            if (w_ea == 8'hFF || w_eb == 8'hFF) begin
                w_res = {w_sa, 8'hFF, 23'd0};
                w_of  = 1'b1;
                w_inf = 1'b1;
            end else if (w_ea == 8'h00 && w_eb == 8'h00) begin
                w_res  = {w_sa & w_sb, 31'd0};
                w_zero = 1'b1;
            end else if (w_ea == w_eb && w_sa == w_sb) begin
                if (w_em[30:23] == 8'hFF) begin
                    w_res = {w_sa, 8'hFF, 23'd0};
                    w_of  = 1'b1;
                    w_inf = 1'b1;
                    w_ix  = 1'b1;
                end else begin
                    w_res = {w_sa, w_em};
                    w_ix  = w_sum[0];
                end
            end else begin
                // Mixed exponents/signs: larger magnitude wins, marked inexact.
                w_res = (Operand_a_DI[30:0] >= Operand_b_DI[30:0]) ? Operand_a_DI : Operand_b_DI;
                w_ix  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Enable_SI) begin
            r_pipe[0] <= {w_res, w_of, 1'b0, w_zero, w_ix, 1'b0, w_inf};
        end
        for (int i = 1; i < LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign {Result_DO, OF_SO, UF_SO, Zero_SO, IX_SO, IV_SO, Inf_SO} = r_pipe[LATENCY-1];

endmodule

// File: rtl/fpu_shared_fifo.sv
// Synchronous show-ahead FIFO; head word visible on o_rd_dat whenever !o_empty.
// Latency: a write becomes visible the cycle after it is written.
// Backpressure: o_full reported; caller guarantees no write when full without a pop.
// Ports: i_wr_vld/i_wr_dat write, i_rd_rdy pop, o_full/o_empty/o_count status.
module fpu_shared_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_wr_vld,
    input  T                             i_wr_dat,
    input  logic                         i_rd_rdy,
    output T                             o_rd_dat,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_rd;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == C_FULL);
    assign o_count  = r_count;
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign w_rd     = i_rd_rdy & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (i_wr_vld) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_vld) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_wr_vld & ~w_rd)      r_count <= r_count + 1'b1;
            else if (~i_wr_vld & w_rd) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/fpu_shared_pipe.sv
// Connects fpu_core to the APU interconnect with optional input register, tag delay line and response FIFO.
// Latency: accept to req_us_s is ADD_REGISTER + CORE_LAT + 1 cycles.
// Backpressure: credit counter stops accepting once FIFO_DEPTH ops are outstanding; ready is register-driven.
// Ports: *_ds_* request side (valid/ready), *_us_* response side (req/ack), busy_o while anything is outstanding.
module fpu_shared_pipe
    import fpu_defs::*;
#(
    parameter int ADD_REGISTER = 1,
    parameter int CORE_LAT     = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              Clk_CI,
    input  logic              Rst_RI,
    input  logic [C_OP-1:0]   arga_ds_d,
    input  logic [C_OP-1:0]   argb_ds_d,
    input  logic [C_CMD-1:0]  op_ds_d,
    input  logic [C_RM-1:0]   flags_ds_d,
    input  logic [C_TAG-1:0]  tag_ds_d,
    input  logic              valid_ds_s,
    output logic              ready_ds_s,
    output logic [C_OP-1:0]   result_us_d,
    output logic [C_FLAG-1:0] flags_us_d,
    output logic [C_TAG-1:0]  tag_us_d,
    output logic              req_us_s,
    input  logic              ack_us_s,
    output logic              busy_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

    logic [CW-1:0]    r_credit;
    logic             w_accept, w_pop;
    logic [C_OP-1:0]  w_core_a, w_core_b, w_core_res;
    logic [C_CMD-1:0] w_core_op;
    logic [C_RM-1:0]  w_core_rm;
    logic [C_TAG-1:0] w_core_tag;
    logic             w_core_en;
    logic             w_of, w_uf, w_zero, w_ix, w_iv, w_inf;
    logic [CORE_LAT-1:0] r_dl_vld;
    logic [C_TAG-1:0]    r_dl_tag [CORE_LAT];
    fpu_resp_t        w_resp, w_head;
    logic             w_full, w_empty;
    logic [CW-1:0]    w_count;

    assign w_accept   = valid_ds_s & ready_ds_s;
    assign w_pop      = req_us_s & ack_us_s;
    assign ready_ds_s = ~Rst_RI & (r_credit < C_DEPTH);
    assign busy_o     = (r_credit != '0);

    // Credits cover everything between accept and pop, so the FIFO always
    // has room for whatever the core is still producing.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_credit <= '0;
        end else if (w_accept & ~w_pop) begin
            r_credit <= r_credit + 1'b1;
        end else if (~w_accept & w_pop) begin
            r_credit <= r_credit - 1'b1;
        end
    end

    if (ADD_REGISTER != 0) begin : g_in_reg
        logic [C_OP-1:0]  r_a, r_b;
        logic [C_CMD-1:0] r_op;
        logic [C_RM-1:0]  r_rm;
        logic [C_TAG-1:0] r_tag;
        logic             r_vld;

        always_ff @(posedge Clk_CI) begin
            r_a   <= arga_ds_d;
            r_b   <= argb_ds_d;
            r_op  <= op_ds_d;
            r_rm  <= flags_ds_d;
            r_tag <= tag_ds_d;
        end

        always_ff @(posedge Clk_CI) begin
            if (Rst_RI) r_vld <= 1'b0;
            else        r_vld <= w_accept;
        end

        assign w_core_a   = r_a;
        assign w_core_b   = r_b;
        assign w_core_op  = r_op;
        assign w_core_rm  = r_rm;
        assign w_core_tag = r_tag;
        assign w_core_en  = r_vld;
    end else begin : g_in_bypass
        assign w_core_a   = arga_ds_d;
        assign w_core_b   = argb_ds_d;
        assign w_core_op  = op_ds_d;
        assign w_core_rm  = flags_ds_d;
        assign w_core_tag = tag_ds_d;
        assign w_core_en  = w_accept;
    end

    fpu_core #(
        .LATENCY      (CORE_LAT)
    ) u_core (
        .Clk_CI       (Clk_CI),
        .Operand_a_DI (w_core_a),
        .Operand_b_DI (w_core_b),
        .RM_SI        (w_core_rm),
        .OP_SI        (w_core_op),
        .Enable_SI    (w_core_en),
        .Result_DO    (w_core_res),
        .OF_SO        (w_of),
        .UF_SO        (w_uf),
        .Zero_SO      (w_zero),
        .IX_SO        (w_ix),
        .IV_SO        (w_iv),
        .Inf_SO       (w_inf)
    );

    // Delay line tracks the core pipeline; its last stage lines up with Result_DO.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_dl_vld <= '0;
        end else begin
            r_dl_vld[0] <= w_core_en;
            for (int i = 1; i < CORE_LAT; i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        r_dl_tag[0] <= w_core_tag;
        for (int i = 1; i < CORE_LAT; i++) begin
            r_dl_tag[i] <= r_dl_tag[i-1];
        end
    end

    assign w_resp.result = w_core_res;
    assign w_resp.flags  = fpu_map_flags(w_inf, w_iv, w_ix, w_zero, w_uf, w_of);
    assign w_resp.tag    = r_dl_tag[CORE_LAT-1];

    fpu_shared_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .T        (fpu_resp_t)
    ) u_fifo (
        .i_clk    (Clk_CI),
        .i_rst    (Rst_RI),
        .i_wr_vld (r_dl_vld[CORE_LAT-1]),
        .i_wr_dat (w_resp),
        .i_rd_rdy (ack_us_s),
        .o_rd_dat (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count)
    );

    assign req_us_s    = ~w_empty;
    assign result_us_d = w_head.result;
    assign flags_us_d  = w_head.flags;
    assign tag_us_d    = w_head.tag;

    a_credit_bound: assert property (@(posedge Clk_CI) disable iff (Rst_RI)
        r_credit <= C_DEPTH);
    a_no_overflow: assert property (@(posedge Clk_CI) disable iff (Rst_RI)
        !(r_dl_vld[CORE_LAT-1] && w_full && !w_pop));
    a_count_covered: assert property (@(posedge Clk_CI) disable iff (Rst_RI)
        w_count <= r_credit);

endmodule

// File: tb/tb_fpu_shared_pipe.sv
module tb_fpu_shared_pipe;
    import fpu_defs::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: ADD_REGISTER=1, CORE_LAT=1, FIFO_DEPTH=4
    logic [C_OP-1:0]   a_a, a_b, a_res;
    logic [C_CMD-1:0]  a_op;
    logic [C_RM-1:0]   a_rm;
    logic [C_TAG-1:0]  a_tag, a_rtag;
    logic [C_FLAG-1:0] a_flags;
    logic              a_vld, a_rdy, a_req, a_ack, a_busy;

    // DUT B: ADD_REGISTER=0, CORE_LAT=2, FIFO_DEPTH=4
    logic [C_OP-1:0]   b_a, b_b, b_res;
    logic [C_CMD-1:0]  b_op;
    logic [C_RM-1:0]   b_rm;
    logic [C_TAG-1:0]  b_tag, b_rtag;
    logic [C_FLAG-1:0] b_flags;
    logic              b_vld, b_rdy, b_req, b_ack, b_busy;

    fpu_shared_pipe #(.ADD_REGISTER(1), .CORE_LAT(1), .FIFO_DEPTH(4)) dut_a (
        .Clk_CI(clk), .Rst_RI(rst),
        .arga_ds_d(a_a), .argb_ds_d(a_b), .op_ds_d(a_op), .flags_ds_d(a_rm),
        .tag_ds_d(a_tag), .valid_ds_s(a_vld), .ready_ds_s(a_rdy),
        .result_us_d(a_res), .flags_us_d(a_flags), .tag_us_d(a_rtag),
        .req_us_s(a_req), .ack_us_s(a_ack), .busy_o(a_busy)
    );

    fpu_shared_pipe #(.ADD_REGISTER(0), .CORE_LAT(2), .FIFO_DEPTH(4)) dut_b (
        .Clk_CI(clk), .Rst_RI(rst),
        .arga_ds_d(b_a), .argb_ds_d(b_b), .op_ds_d(b_op), .flags_ds_d(b_rm),
        .tag_ds_d(b_tag), .valid_ds_s(b_vld), .ready_ds_s(b_rdy),
        .result_us_d(b_res), .flags_us_d(b_flags), .tag_us_d(b_rtag),
        .req_us_s(b_req), .ack_us_s(b_ack), .busy_o(b_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc;
    int exp_tag;

    // Directed vectors for DUT B: operands, rounding mode, expected result and flags.
    logic [31:0] va [7] = '{32'h7F800000, 32'h3F800000, 32'h3FC00000, 32'h00000000,
                            32'h3F800003, 32'h40000000, 32'h3F800003};
    logic [31:0] vb [7] = '{32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h00000000,
                            32'h3F800000, 32'h3F800000, 32'h3F800000};
    logic [2:0]  vm [7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    logic [31:0] vr [7] = '{32'h7F800000, 32'h40000000, 32'h40200000, 32'h00000000,
                            32'h40000002, 32'h40000000, 32'h40000001};
    logic [8:0]  vf [7] = '{9'h081, 9'h000, 9'h000, 9'h010, 9'h020, 9'h020, 9'h020};

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        a_a = '0; a_b = '0; a_op = C_FPU_ADD_CMD; a_rm = '0; a_tag = '0; a_vld = 1'b0; a_ack = 1'b0;
        b_a = '0; b_b = '0; b_op = C_FPU_ADD_CMD; b_rm = '0; b_tag = '0; b_vld = 1'b0; b_ack = 1'b1;

        // Reset state
        cyc(); cyc();
        mid();
        chk("rst_ready", a_rdy, 0);
        chk("rst_req", a_req, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_req_b", b_req, 0);
        cyc(); rst = 1'b0;
        mid();
        chk("rel_ready", a_rdy, 1);
        chk("rel_busy", a_busy, 0);

        // Single op, tag 5, 1.0 + 1.0
        cyc(); a_vld = 1'b1; a_tag = 5'h05; a_a = 32'h3F800000; a_b = 32'h3F800000; a_ack = 1'b1;
        mid(); chk("t1_rdy_c0", a_rdy, 1);
        cyc(); a_vld = 1'b0;
        mid(); chk("t1_req_c1", a_req, 0); chk("t1_busy_c1", a_busy, 1);
        cyc();
        mid(); chk("t1_req_c2", a_req, 0);
        cyc();
        mid();
        chk("t1_req_c3", a_req, 1);
        chk("t1_tag_c3", a_rtag, 5);
        chk("t1_res_c3", a_res, 32'h40000000);
        chk("t1_flags_c3", a_flags, 0);
        cyc();
        mid(); chk("t1_req_c4", a_req, 0); chk("t1_busy_c4", a_busy, 0);

        // Back-to-back: tags 0..9, responses on cycles 3..12
        for (int k = 0; k < 14; k++) begin
            cyc();
            if (k < 10) begin a_vld = 1'b1; a_tag = k[4:0]; end
            else        a_vld = 1'b0;
            mid();
            if (k < 10) chk("t2_rdy", a_rdy, 1);
            if (k >= 3 && k < 13) begin
                chk("t2_req", a_req, 1);
                chk("t2_tag", a_rtag, k - 3);
            end else begin
                chk("t2_idle", a_req, 0);
            end
        end

        // Back-pressure: ack low, valid held high
        a_ack = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(); a_vld = 1'b1; a_tag = n_acc[4:0];
            mid();
            if (a_rdy) n_acc++;
            if (k >= 3) begin
                chk("t3_req_hold", a_req, 1);
                chk("t3_head_hold", a_rtag, 0);
            end
        end
        chk("t3_accepts", n_acc, 4);
        chk("t3_rdy_low", a_rdy, 0);
        cyc(); a_ack = 1'b1;
        mid(); chk("t3_rdy_at_pop", a_rdy, 0); chk("t3_head_at_pop", a_rtag, 0);
        cyc(); a_ack = 1'b0;
        mid();
        chk("t3_rdy_after_pop", a_rdy, 1);
        chk("t3_head_after_pop", a_rtag, 1);
        if (a_rdy) n_acc++;

        // Accept and pop overlapping with a full credit window; order and count preserved
        exp_tag = 1;
        for (int k = 0; k < 14; k++) begin
            cyc(); a_ack = 1'b1;
            if (k < 8) begin a_vld = 1'b1; a_tag = n_acc[4:0]; end
            else       a_vld = 1'b0;
            mid();
            if (k == 0) chk("t4_rdy_full", a_rdy, 0);
            else if (k < 8) chk("t4_rdy_overlap", a_rdy, 1);
            if (a_vld && a_rdy) n_acc++;
            if (a_req) begin
                chk("t4_order", a_rtag, exp_tag);
                exp_tag++;
            end
        end
        chk("t4_accepts", n_acc, 12);
        chk("t4_responses", exp_tag, 12);
        chk("t4_busy_end", a_busy, 0);

        // Reset mid-stream: 2 buffered + 2 in flight, none may reappear
        a_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(); a_vld = 1'b1; a_tag = 5'(16 + k);
            mid(); chk("t5_rdy_fill", a_rdy, 1);
        end
        cyc(); a_vld = 1'b0; rst = 1'b1;
        mid();
        chk("t5_rdy_in_rst", a_rdy, 0);
        chk("t5_buffered", a_req, 1);
        chk("t5_buffered_tag", a_rtag, 16);
        cyc(); rst = 1'b0; a_ack = 1'b1;
        mid();
        chk("t5_req_after", a_req, 0);
        chk("t5_busy_after", a_busy, 0);
        chk("t5_rdy_after", a_rdy, 1);
        for (int k = 0; k < 6; k++) begin
            cyc();
            mid(); chk("t5_no_ghost", a_req, 0);
        end
        cyc(); a_vld = 1'b1; a_tag = 5'h1A; a_a = 32'h3FC00000; a_b = 32'h3F800000;
        mid(); chk("t5_post_rdy", a_rdy, 1);
        cyc(); a_vld = 1'b0;
        cyc(); cyc();
        mid();
        chk("t5_post_req", a_req, 1);
        chk("t5_post_tag", a_rtag, 32'h1A);
        chk("t5_post_res", a_res, 32'h40200000);

        // Flag mapping and arithmetic vectors on DUT B, back-to-back
        for (int k = 0; k < 11; k++) begin
            cyc();
            if (k < 7) begin
                b_vld = 1'b1; b_tag = k[4:0]; b_a = va[k]; b_b = vb[k]; b_rm = vm[k];
            end else begin
                b_vld = 1'b0;
            end
            mid();
            if (k < 7) chk("t6_rdy", b_rdy, 1);
            if (k >= 3 && k < 10) begin
                chk("t6_req", b_req, 1);
                chk("t6_tag", b_rtag, k - 3);
                chk("t6_res", b_res, vr[k-3]);
                chk("t6_flags", b_flags, {23'd0, vf[k-3]});
            end else begin
                chk("t6_idle", b_req, 0);
            end
        end
        chk("t6_busy_end", b_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
